// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial values to an external
// comparator, resolves the target MSB first and reports result/hit/err with a done pulse.
module sar_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             tgt_gt_trial,
  input  logic             tgt_lt_trial,
  input  logic             tgt_eq_trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hit,
  output logic             err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] trial_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             done_q;
  logic             hit_q;
  logic             err_q;
  logic [IW-1:0]    bitIdx_q;
  logic [CW-1:0]    settleCnt_q;

  logic             sampleNow_d;
  logic             flagsOneHot_d;
  logic [WIDTH-1:0] decidedTrial_d;
  logic [WIDTH-1:0] nextTrial_d;

  // Decision on the current bit and the probe of the next bit are formed together,
  // so both land on the same sample edge.
  always_comb begin
    sampleNow_d    = (settleCnt_q == CW'(SETTLE - 1));
    flagsOneHot_d  = $onehot({tgt_gt_trial, tgt_lt_trial, tgt_eq_trial});
    decidedTrial_d = trial_q;
    if (tgt_lt_trial) begin
      decidedTrial_d[bitIdx_q] = 1'b0;
    end
    nextTrial_d = decidedTrial_d;
    if (bitIdx_q != '0) begin
      nextTrial_d[bitIdx_q - IW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      trial_q     <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hit_q       <= 1'b0;
      err_q       <= 1'b0;
      bitIdx_q    <= '0;
      settleCnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            trial_q     <= WIDTH'(1) << (WIDTH - 1);
            busy_q      <= 1'b1;
            bitIdx_q    <= IW'(WIDTH - 1);
            settleCnt_q <= '0;
            hit_q       <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!sampleNow_d) begin
            settleCnt_q <= settleCnt_q + CW'(1);
          end else if (!flagsOneHot_d) begin
            err_q    <= 1'b1;
            result_q <= '0;
            trial_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else if (tgt_eq_trial) begin
            result_q <= trial_q;
            hit_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else if (bitIdx_q == '0) begin
            result_q <= decidedTrial_d;
            trial_q  <= decidedTrial_d;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            trial_q     <= nextTrial_d;
            bitIdx_q    <= bitIdx_q - IW'(1);
            settleCnt_q <= '0;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign hit    = hit_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: two instances (SETTLE=1 and SETTLE=3) against behavioural
// comparators, a per-cycle timeline model and hand-computed literal pins.
module tb_sar_search_ctrl;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start1, start3;
  logic [7:0] tgt1, tgt3;
  logic       forceZero;

  logic [7:0] trial1, result1, trial3, result3;
  logic       gt1, lt1, eq1, busy1, done1, hit1, err1;
  logic       gt3, lt3, eq3, busy3, done3, hit3, err3;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct packed {
    logic [7:0] trial;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       hit;
    logic       err;
  } expT;

  expT        q1[$];
  expT        q3[$];
  logic [7:0] lastTrial[2];
  logic [7:0] lastRes[2];
  logic       lastHit[2];
  logic       lastErr[2];

  logic [7:0] seenTrial[0:31];
  logic       busySeen;

  always #5 clk = ~clk;

  sar_search_ctrl #(.WIDTH(8), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rstN), .start(start1), .trial(trial1),
    .tgt_gt_trial(gt1), .tgt_lt_trial(lt1), .tgt_eq_trial(eq1),
    .busy(busy1), .done(done1), .result(result1), .hit(hit1), .err(err1)
  );

  sar_search_ctrl #(.WIDTH(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rstN), .start(start3), .trial(trial3),
    .tgt_gt_trial(gt3), .tgt_lt_trial(lt3), .tgt_eq_trial(eq3),
    .busy(busy3), .done(done3), .result(result3), .hit(hit3), .err(err3)
  );

  // Behavioural comparators; forceZero models a dead comparator.
  always_comb begin
    gt1 = !forceZero && (tgt1 > trial1);
    lt1 = !forceZero && (tgt1 < trial1);
    eq1 = !forceZero && (tgt1 == trial1);
    gt3 = !forceZero && (tgt3 > trial3);
    lt3 = !forceZero && (tgt3 < trial3);
    eq3 = !forceZero && (tgt3 == trial3);
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-cycle output timeline of one search, by binary search on the target.
  task automatic planSearch(input int which, input logic [7:0] tgtVal, input int errStep);
    int         s = (which == 0) ? 1 : 3;
    int         acc = 0;
    int         t;
    bit         fin = 0;
    logic [7:0] res = '0;
    logic       h = 1'b0;
    logic       e = 1'b0;
    logic [7:0] prevRes = lastRes[which];
    expT        x;
    for (int k = 1; k <= 8 && !fin; k++) begin
      t = acc + (1 << (8 - k));
      for (int c = 0; c < s; c++) begin
        x = '{trial: 8'(t), busy: 1'b1, done: 1'b0, result: prevRes, hit: 1'b0, err: 1'b0};
        if (which == 0) q1.push_back(x); else q3.push_back(x);
      end
      if (k == errStep) begin
        res = '0; h = 1'b0; e = 1'b1; fin = 1;
      end else if (t == int'(tgtVal)) begin
        res = 8'(t); h = 1'b1; fin = 1;
      end else begin
        if (int'(tgtVal) > t) acc = t;
        if (k == 8) begin
          res = 8'(acc); fin = 1;
        end
      end
    end
    x = '{trial: res, busy: 1'b0, done: 1'b1, result: res, hit: h, err: e};
    if (which == 0) q1.push_back(x); else q3.push_back(x);
    lastTrial[which] = res;
    lastRes[which]   = res;
    lastHit[which]   = h;
    lastErr[which]   = e;
  endtask

  task automatic compareDut(input int which, input logic [19:0] act);
    expT x;
    if (which == 0 && q1.size() > 0) x = q1.pop_front();
    else if (which == 1 && q3.size() > 0) x = q3.pop_front();
    else x = '{trial: lastTrial[which], busy: 1'b0, done: 1'b0,
               result: lastRes[which], hit: lastHit[which], err: lastErr[which]};
    checkVal((which == 0) ? "dut1 cycle" : "dut3 cycle", {12'd0, act}, {12'd0, x});
  endtask

  always @(negedge clk) begin
    compareDut(0, {trial1, busy1, done1, result1, hit1, err1});
    compareDut(1, {trial3, busy3, done3, result3, hit3, err3});
  end

  task automatic applyStimulus(input int which, input logic [7:0] tgtVal, input int errStep,
                               input int holdStart, output int doneAt, output logic [7:0] resSeen,
                               output logic hitSeen, output logic errSeen);
    int s = (which == 0) ? 1 : 3;
    if (which == 0) tgt1 = tgtVal; else tgt3 = tgtVal;
    @(negedge clk);
    #1;
    if (which == 0) start1 = 1'b1; else start3 = 1'b1;
    planSearch(which, tgtVal, errStep);
    doneAt = 0; resSeen = '0; hitSeen = 1'b0; errSeen = 1'b0;
    for (int n = 1; n <= 200 && doneAt == 0; n++) begin
      @(negedge clk);
      if (n >= holdStart) begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
      if (n < 32) seenTrial[n] = (which == 0) ? trial1 : trial3;
      if ((which == 0) ? done1 : done3) begin
        doneAt   = n;
        resSeen  = (which == 0) ? result1 : result3;
        hitSeen  = (which == 0) ? hit1 : hit3;
        errSeen  = (which == 0) ? err1 : err3;
        busySeen = (which == 0) ? busy1 : busy3;
      end
      forceZero = (errStep != 0) && (n == errStep * s);
    end
    forceZero = 1'b0;
    if (doneAt == 0) checkVal("done timeout", 32'd0, 32'd1);
  endtask

  task automatic checkOutput(input string name, input int doneAt, input logic [7:0] resSeen,
                             input logic hitSeen, input logic errSeen, input int expDone,
                             input logic [7:0] expRes, input logic expHit, input logic expErr);
    checkVal({name, " done cycle"}, doneAt, expDone);
    checkVal({name, " result"}, {24'd0, resSeen}, {24'd0, expRes});
    checkVal({name, " hit"}, {31'd0, hitSeen}, {31'd0, expHit});
    checkVal({name, " err"}, {31'd0, errSeen}, {31'd0, expErr});
  endtask

  initial begin
    int         dAt;
    logic [7:0] r;
    logic       h, e;
    logic [7:0] seqA5[8];
    seqA5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    for (int i = 0; i < 2; i++) begin
      lastTrial[i] = '0; lastRes[i] = '0; lastHit[i] = 1'b0; lastErr[i] = 1'b0;
    end
    rstN = 1'b0; start1 = 1'b0; start3 = 1'b0; forceZero = 1'b0;
    tgt1 = '0; tgt3 = '0; busySeen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset trial/busy/done", {22'd0, trial1, busy1, done1}, 32'd0);
    checkVal("reset result/hit/err", {22'd0, result1, hit1, err1}, 32'd0);
    rstN = 1'b1;

    // Start held for three edges: the extra starts arrive while busy and are ignored.
    applyStimulus(0, 8'hA5, 0, 3, dAt, r, h, e);
    for (int i = 0; i < 8; i++) checkVal($sformatf("A5 trial step %0d", i + 1),
                                         {24'd0, seenTrial[i + 1]}, {24'd0, seqA5[i]});
    checkOutput("A5", dAt, r, h, e, 9, 8'hA5, 1'b1, 1'b0);

    applyStimulus(0, 8'h80, 0, 1, dAt, r, h, e);
    checkOutput("80", dAt, r, h, e, 2, 8'h80, 1'b1, 1'b0);
    checkVal("80 busy at done", {31'd0, busySeen}, 32'd0);

    applyStimulus(0, 8'h00, 0, 1, dAt, r, h, e);
    checkOutput("00", dAt, r, h, e, 9, 8'h00, 1'b0, 1'b0);

    applyStimulus(0, 8'hFF, 0, 1, dAt, r, h, e);
    checkOutput("FF", dAt, r, h, e, 9, 8'hFF, 1'b1, 1'b0);

    applyStimulus(0, 8'h37, 3, 1, dAt, r, h, e);
    checkOutput("dead flags", dAt, r, h, e, 4, 8'h00, 1'b0, 1'b1);

    applyStimulus(0, 8'h37, 0, 1, dAt, r, h, e);
    checkOutput("37 after err", dAt, r, h, e, 9, 8'h37, 1'b1, 1'b0);

    applyStimulus(1, 8'h3C, 0, 1, dAt, r, h, e);
    checkOutput("S3 3C", dAt, r, h, e, 19, 8'h3C, 1'b1, 1'b0);
    checkVal("S3 trial held", {8'd0, seenTrial[1], seenTrial[2], seenTrial[3]}, 32'h808080);
    checkVal("S3 second trial", {24'd0, seenTrial[4]}, 32'h40);

    // Reset during step 4 of a search on dut1 (dut3 still holds 3C until then).
    tgt1 = 8'h5A;
    @(negedge clk);
    #1;
    start1 = 1'b1;
    planSearch(0, 8'h5A, 0);
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b0;
    q1.delete();
    q3.delete();
    for (int i = 0; i < 2; i++) begin
      lastTrial[i] = '0; lastRes[i] = '0; lastHit[i] = 1'b0; lastErr[i] = 1'b0;
    end
    #1;
    checkVal("abort dut1 outputs", {12'd0, trial1, busy1, done1, result1, hit1, err1}, 32'd0);
    checkVal("abort dut3 result", {24'd0, result3}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstN = 1'b1;

    applyStimulus(0, 8'h5A, 0, 1, dAt, r, h, e);
    checkOutput("5A after reset", dAt, r, h, e, 8, 8'h5A, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
